pipe_if_stage: RTL and testbench

Instruction-fetch stage of the five-stage pipeline, directly upstream of the pipeline control unit's ID-stage consumer. Owns the PC, drives the instruction-memory request, and writes the IF/ID pipeline register. It obeys the control unit's `IFwip` stall enable and `IFwillJump` redirect. A one-entry hold buffer keeps a word that returns from memory while ID is stalled.

---
 rtl/pipe_pkg.sv | 29 ++
 rtl/pipe_if_holdbuf.sv | 39 +++
 rtl/pipe_if_stage.sv | 141 ++++++++++++++
 tb/tb_pipe_if_stage.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline definitions.
// Holds the IF-stage state encoding, PC arithmetic constants, the default
// bubble word and the PC helper functions used by the fetch stage.
package pipe_pkg;

    localparam int unsigned PC_W    = 32;
    localparam int unsigned INST_W  = 32;
    localparam int unsigned PC_STEP = 4;

    // Default bubble word written into IF/ID.
    localparam logic [INST_W-1:0] DEFAULT_NOP_INST = 32'h0000_0000;

    // FETCH: request outstanding; HELD: word parked in the hold buffer.
    typedef enum logic {
        FETCH = 1'b0,
        HELD  = 1'b1
    } if_state_t;

    // Sequential PC; wraps modulo 2^PC_W.
    function automatic logic [PC_W-1:0] pc_inc(input logic [PC_W-1:0] pc);
        return pc + PC_W'(PC_STEP);
    endfunction

    // Force word alignment of a PC or redirect target.
    function automatic logic [PC_W-1:0] pc_align(input logic [PC_W-1:0] addr);
        return addr & ~PC_W'(PC_STEP - 1);
    endfunction

endpackage

// File: rtl/pipe_if_holdbuf.sv
// One-entry hold buffer for the fetch stage.
// Parks an instruction word that returned while ID was stalled.
// Ports:
//   clock, resetn     clock and synchronous active-low reset
//   load, load_data   capture a word (buffer becomes valid)
//   drain             hand the word onward (buffer becomes empty)
//   flush             drop the contents; wins over load and drain
//   hb_valid, hb_data buffer contents
module pipe_if_holdbuf
    import pipe_pkg::*;
#(
    parameter int unsigned DATA_W = INST_W
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              load,
    input  logic [DATA_W-1:0] load_data,
    input  logic              drain,
    input  logic              flush,
    output logic              hb_valid,
    output logic [DATA_W-1:0] hb_data
);

    // Valid flag and payload; payload only changes on load.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            hb_valid <= 1'b0;
            hb_data  <= '0;
        end else if (flush) begin
            hb_valid <= 1'b0;
        end else if (load) begin
            hb_valid <= 1'b1;
            hb_data  <= load_data;
        end else if (drain) begin
            hb_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/pipe_if_stage.sv
// Instruction-fetch stage: owns the PC, drives the instruction-memory
// request and writes the IF/ID pipeline register. Obeys the control unit's
// stall enable (IFwip) and redirect (IFwillJump). A one-entry hold buffer
// keeps a word that returned from memory while ID was stalled.
// Ports:
//   clock, resetn             clock and synchronous active-low reset
//   IFwip                     PC / IF-ID write enable (0 = stall)
//   IFwillJump, MEMjumpTarget redirect request and target from MEM
//   imem_addr, imem_req       fetch address (= pc) and request (= FETCH)
//   imem_rdata, imem_ready    returned instruction word and its strobe
//   IDinst, IDpc4, IDvalid    IF/ID pipeline register
// Optional feature macro PIPE_IF_PERF_EN adds perf_stall_cycles and
// perf_redirects wrap-around counters.
module pipe_if_stage
    import pipe_pkg::*;
#(
    parameter logic [PC_W-1:0]   RESET_PC = 32'h0000_0000,
    parameter logic [INST_W-1:0] NOP_INST = DEFAULT_NOP_INST
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              IFwip,
    input  logic              IFwillJump,
    input  logic [PC_W-1:0]   MEMjumpTarget,
    output logic [PC_W-1:0]   imem_addr,
    output logic              imem_req,
    input  logic [INST_W-1:0] imem_rdata,
    input  logic              imem_ready,
    output logic [INST_W-1:0] IDinst,
    output logic [PC_W-1:0]   IDpc4,
    output logic              IDvalid
`ifdef PIPE_IF_PERF_EN
    ,
    output logic [31:0]       perf_stall_cycles,
    output logic [31:0]       perf_redirects
`endif
);

    logic [PC_W-1:0]   pc;
    logic [PC_W-1:0]   pc_plus4;
    if_state_t         state;

    logic              hb_load;
    logic              hb_drain;
    logic              hb_flush;
    logic              hb_valid;
    logic [INST_W-1:0] hb_data;

    // Memory interface is driven straight from registers.
    assign imem_addr = pc;
    assign imem_req  = (state == FETCH);
    assign pc_plus4  = pc_inc(pc);

    // Hold-buffer controls mirror the priority of the main state update.
    always_comb begin
        hb_flush = 1'b0;
        hb_load  = 1'b0;
        hb_drain = 1'b0;
        if (IFwillJump) begin
            hb_flush = 1'b1;
        end else if (state == FETCH) begin
            hb_load = imem_ready && !IFwip;
        end else begin
            hb_drain = IFwip;
        end
    end

    pipe_if_holdbuf #(
        .DATA_W (INST_W)
    ) u_holdbuf (
        .clock     (clock),
        .resetn    (resetn),
        .load      (hb_load),
        .load_data (imem_rdata),
        .drain     (hb_drain),
        .flush     (hb_flush),
        .hb_valid  (hb_valid),
        .hb_data   (hb_data)
    );

    // PC, fetch FSM and IF/ID register: reset > redirect > stall > wait > advance.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            pc      <= pc_align(RESET_PC);
            state   <= FETCH;
            IDinst  <= NOP_INST;
            IDpc4   <= '0;
            IDvalid <= 1'b0;
        end else if (IFwillJump) begin
            // Any word returning this cycle belongs to the squashed path.
            pc      <= pc_align(MEMjumpTarget);
            state   <= FETCH;
            IDinst  <= NOP_INST;
            IDvalid <= 1'b0;
        end else begin
            unique case (state)
                FETCH: begin
                    if (IFwip) begin
                        if (imem_ready) begin
                            IDinst  <= imem_rdata;
                            IDpc4   <= pc_plus4;
                            IDvalid <= 1'b1;
                            pc      <= pc_plus4;
                        end else begin
                            IDinst  <= NOP_INST;
                            IDvalid <= 1'b0;
                        end
                    end else if (imem_ready) begin
                        // ID is stalled: park the word, drop the request.
                        state <= HELD;
                    end
                end
                HELD: begin
                    // Memory is not re-accessed; the parked word goes to ID.
                    if (IFwip) begin
                        IDinst  <= hb_data;
                        IDpc4   <= pc_plus4;
                        IDvalid <= hb_valid;
                        pc      <= pc_plus4;
                        state   <= FETCH;
                    end
                end
            endcase
        end
    end

`ifdef PIPE_IF_PERF_EN
    // Stall and redirect event counters; wrap on overflow.
    always_ff @(posedge clock) begin
        if (!resetn) begin
            perf_stall_cycles <= '0;
            perf_redirects    <= '0;
        end else if (IFwillJump) begin
            perf_redirects    <= perf_redirects + 32'd1;
        end else if (!IFwip) begin
            perf_stall_cycles <= perf_stall_cycles + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_pipe_if_stage.sv
// Self-checking bench for pipe_if_stage: directed test-plan steps followed
// by randomized traffic, all compared against a transaction-level model.
module tb_pipe_if_stage;

    logic        clock;
    logic        resetn;
    logic        IFwip;
    logic        IFwillJump;
    logic [31:0] MEMjumpTarget;
    logic [31:0] imem_addr;
    logic        imem_req;
    logic [31:0] imem_rdata;
    logic        imem_ready;
    logic [31:0] IDinst;
    logic [31:0] IDpc4;
    logic        IDvalid;
`ifdef PIPE_IF_PERF_EN
    logic [31:0] perf_stall_cycles;
    logic [31:0] perf_redirects;
`endif

    localparam logic [31:0] NOP = 32'h0000_0000;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state.
    bit          m_known = 0;
    logic [31:0] m_pc;
    logic [31:0] m_inst;
    logic [31:0] m_pc4;
    logic        m_valid;
    logic [31:0] m_held[$];
    logic [31:0] m_stalls;
    logic [31:0] m_redirs;

    pipe_if_stage dut (
        .clock         (clock),
        .resetn        (resetn),
        .IFwip         (IFwip),
        .IFwillJump    (IFwillJump),
        .MEMjumpTarget (MEMjumpTarget),
        .imem_addr     (imem_addr),
        .imem_req      (imem_req),
        .imem_rdata    (imem_rdata),
        .imem_ready    (imem_ready),
        .IDinst        (IDinst),
        .IDpc4         (IDpc4),
        .IDvalid       (IDvalid)
`ifdef PIPE_IF_PERF_EN
        ,
        .perf_stall_cycles (perf_stall_cycles),
        .perf_redirects    (perf_redirects)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Memory image: the word at address A is A + 0x100.
    function automatic logic [31:0] word_at(input logic [31:0] a);
        return a + 32'h100;
    endfunction

    assign imem_rdata = imem_ready ? word_at(imem_addr) : 32'hDEAD_BEEF;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        check("imem_addr", imem_addr, m_pc);
        check("imem_req",  32'(imem_req), 32'(m_held.size() == 0));
        check("IDinst",    IDinst, m_inst);
        check("IDpc4",     IDpc4, m_pc4);
        check("IDvalid",   32'(IDvalid), 32'(m_valid));
`ifdef PIPE_IF_PERF_EN
        check("perf_stall_cycles", perf_stall_cycles, m_stalls);
        check("perf_redirects",    perf_redirects, m_redirs);
`endif
    endtask

    // Apply one cycle of inputs, then advance the model by one edge.
    task automatic step(input logic rn, input logic wip, input logic jmp,
                        input logic rdy, input logic [31:0] tgt);
        @(negedge clock);
        if (m_known) check_outputs();
        resetn        = rn;
        IFwip         = wip;
        IFwillJump    = jmp;
        imem_ready    = rdy;
        MEMjumpTarget = tgt;
        @(posedge clock);
        if (!rn) begin
            m_known  = 1;
            m_pc     = 32'h0;
            m_inst   = NOP;
            m_pc4    = 32'h0;
            m_valid  = 1'b0;
            m_held.delete();
            m_stalls = 32'h0;
            m_redirs = 32'h0;
        end else if (jmp) begin
            m_redirs = m_redirs + 1;
            m_pc     = {tgt[31:2], 2'b00};
            m_inst   = NOP;
            m_valid  = 1'b0;
            m_held.delete();
        end else begin
            if (!wip) m_stalls = m_stalls + 1;
            if (m_held.size() != 0) begin
                if (wip) begin
                    m_inst  = m_held.pop_front();
                    m_pc4   = m_pc + 4;
                    m_valid = 1'b1;
                    m_pc    = m_pc + 4;
                end
            end else if (!wip) begin
                if (rdy) m_held.push_back(word_at(m_pc));
            end else if (rdy) begin
                m_inst  = word_at(m_pc);
                m_pc4   = m_pc + 4;
                m_valid = 1'b1;
                m_pc    = m_pc + 4;
            end else begin
                m_inst  = NOP;
                m_valid = 1'b0;
            end
        end
        #1;
    endtask

    initial begin
        resetn = 1'b0; IFwip = 1'b1; IFwillJump = 1'b0;
        imem_ready = 1'b1; MEMjumpTarget = 32'h0;

        // Reset for two cycles.
        step(0, 1, 0, 1, 0);
        step(0, 1, 0, 1, 0);
        check("reset_addr",  imem_addr, 32'h0);
        check("reset_valid", 32'(IDvalid), 32'h0);

        // Streaming fetch 0x00..0x1C.
        for (int i = 0; i < 8; i++) step(1, 1, 0, 1, 0);
        check("stream_inst", IDinst, 32'h11C);
        check("stream_addr", imem_addr, 32'h20);

        // Memory wait at 0x20: three bubbles.
        for (int i = 0; i < 3; i++) step(1, 1, 0, 0, 0);
        check("wait_addr",  imem_addr, 32'h20);
        check("wait_inst",  IDinst, NOP);

        // Advance to 0x40, then stall two cycles with the word arriving.
        for (int i = 0; i < 8; i++) step(1, 1, 0, 1, 0);
        step(1, 0, 0, 1, 0);
        check("held_req", 32'(imem_req), 32'h0);
        step(1, 0, 0, 1, 0);
        check("held_inst", IDinst, 32'h13C);
        step(1, 1, 0, 0, 0);
        check("release_inst", IDinst, 32'h140);
        check("release_pc4",  IDpc4, 32'h44);
        check("release_addr", imem_addr, 32'h44);

        // Redirect while HELD and stalled.
        step(1, 0, 0, 1, 0);
        step(1, 0, 1, 1, 32'h203);
        check("redir_valid", 32'(IDvalid), 32'h0);
        check("redir_addr",  imem_addr, 32'h200);
        check("redir_req",   32'(imem_req), 32'h1);

        // PC wrap at the top of the address space.
        step(1, 1, 1, 1, 32'hFFFF_FFFC);
        step(1, 1, 0, 1, 0);
        check("wrap_pc4",  IDpc4, 32'h0);
        check("wrap_addr", imem_addr, 32'h0);
        check("wrap_inst", IDinst, 32'h0000_00FC);

`ifdef PIPE_IF_PERF_EN
        // Five stalls and two redirects from a clean reset.
        step(0, 1, 0, 1, 0);
        for (int i = 0; i < 5; i++) step(1, 0, 0, 1, 0);
        step(1, 1, 1, 1, 32'h80);
        step(1, 0, 1, 0, 32'h90);
        check("perf_stalls_5", perf_stall_cycles, 32'd5);
        check("perf_redirs_2", perf_redirects, 32'd2);
        step(0, 1, 0, 1, 0);
        check("perf_stalls_rst", perf_stall_cycles, 32'd0);
        check("perf_redirs_rst", perf_redirects, 32'd0);
`endif

        // Randomized traffic, including resets mid-wait and mid-HELD.
        for (int i = 0; i < 400; i++) begin
            logic rn, wip, jmp, rdy;
            logic [31:0] tgt;
            rn  = ($urandom_range(0, 59) != 0);
            wip = ($urandom_range(0, 3) != 0);
            jmp = ($urandom_range(0, 9) == 0);
            rdy = ($urandom_range(0, 2) != 0);
            tgt = $urandom;
            step(rn, wip, jmp, rdy, tgt);
        end
        @(negedge clock);
        check_outputs();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
